// File: rtl/full_adder_unit.sv
// full_adder_unit
//   Parameterised ripple-carry adder built from per-bit full-adder cells
//   (two half adders plus an OR on their carries). It has two result paths:
//   a zero-latency combinational path (sum, cout) and a registered copy
//   (sum_q, cout_q). The registered copy is loaded only when in_valid is high,
//   and out_valid marks that a new result was loaded.
//
// Parameters
//   WIDTH      operand width in bits, 1..64
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset; clears every register
//   a, b       unsigned operands [WIDTH-1:0]
//   cin        carry into bit 0
//   in_valid   loads the current result into sum_q/cout_q on the next edge
//   sum, cout  combinational result, {cout,sum} = a + b + cin
//   sum_q      registered sum; holds its value while in_valid is low
//   cout_q     registered carry out; holds its value while in_valid is low
//   out_valid  in_valid delayed by one cycle
//   ovf_q      (only when FULL_ADDER_OVF_EN is defined) registered signed
//              overflow, c[WIDTH] ^ c[WIDTH-1]
//
// Build option
//   FULL_ADDER_OVF_EN  adds the ovf_q output and its register.

module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
`ifdef FULL_ADDER_OVF_EN
  output logic             ovf_q,
`endif
  output logic             out_valid
);

  // c[i] is the carry into bit i. c[0] = cin and c[WIDTH] = cout.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] p;  // propagate: sum output of half adder 1
  logic [WIDTH-1:0] g;  // generate:  carry output of half adder 1
  logic [WIDTH-1:0] t;  // carry output of half adder 2

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    // First half adder: combines the two operand bits.
    assign p[i]   = a[i] ^ b[i];
    assign g[i]   = a[i] & b[i];
    // Second half adder: adds the incoming carry to p.
    assign sum[i] = p[i] ^ c[i];
    assign t[i]   = p[i] & c[i];
    // The two half-adder carries can never both be 1, so OR is enough.
    assign c[i+1] = g[i] | t[i];
  end

  assign cout = c[WIDTH];

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow occurs when the carry into the sign bit differs from the
  // carry out of it. When WIDTH=1, c[WIDTH-1] is c[0], which is cin.
  logic ovf;
  assign ovf = c[WIDTH] ^ c[WIDTH-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q  <= sum;
        cout_q <= cout;
`ifdef FULL_ADDER_OVF_EN
        ovf_q  <= ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// tb_full_adder_unit
//   Bench for full_adder_unit. It instantiates two copies of the design: one
//   with WIDTH=1 and one with WIDTH=8. A behavioural model computes the
//   expected results with plain integer arithmetic. If FULL_ADDER_OVF_EN is
//   defined, the bench also checks ovf_q.

module tb_full_adder_unit;

  logic clk;
  logic rst_n;

  logic       a1, b1, cin1, iv1;
  logic       sum1, cout1, sq1, cq1, ov1;

  logic [7:0] a8, b8;
  logic       cin8, iv8;
  logic [7:0] sum8, sq8;
  logic       cout8, cq8, ov8;

`ifdef FULL_ADDER_OVF_EN
  logic       of1, of8;
`endif

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  full_adder_unit #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
    .sum(sum1), .cout(cout1), .sum_q(sq1), .cout_q(cq1),
`ifdef FULL_ADDER_OVF_EN
    .ovf_q(of1),
`endif
    .out_valid(ov1)
  );

  full_adder_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
    .sum(sum8), .cout(cout8), .sum_q(sq8), .cout_q(cq8),
`ifdef FULL_ADDER_OVF_EN
    .ovf_q(of8),
`endif
    .out_valid(ov8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the result of an unsigned addition, computed at 9 bits.
  function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    int s;
    s = int'(x) + int'(y) + int'(ci);
    return s[8:0];
  endfunction

  // Reference model: signed overflow, meaning the true signed sum does not
  // fit in 8 bits.
  function automatic logic ref_ovf8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(ci);
    return (s > 127) || (s < -128);
  endfunction

  logic [1:0] tbl1 [8];     // expected {sum,cout} for each 1-bit input step
  logic [7:0] bb_a [3];
  logic [7:0] bb_b [3];
  logic       bb_c [3];
  logic [7:0] bb_s [3];
  logic       bb_co[3];
  logic [8:0] r;
  logic [7:0] m_sq;
  logic       m_cq, m_of, m_ov;
  int         s1;

  initial begin
    tbl1 = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    bb_a = '{8'd3, 8'd200, 8'd0};
    bb_b = '{8'd4, 8'd100, 8'd0};
    bb_c = '{1'b0, 1'b1, 1'b0};
    bb_s = '{8'd7, 8'd45, 8'd0};
    bb_co = '{1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
    a8 = 0; b8 = 0; cin8 = 0; iv8 = 0;
    #2;
    chk("rst_sq1", 64'(sq1), 64'd0);
    chk("rst_cq1", 64'(cq1), 64'd0);
    chk("rst_ov1", 64'(ov1), 64'd0);
    chk("rst_sq8", 64'(sq8), 64'd0);
    chk("rst_cq8", 64'(cq8), 64'd0);
    chk("rst_ov8", 64'(ov8), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Step through all eight 1-bit input combinations and check the
    // combinational outputs.
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; cin1 = i[0];
      #1;
      s1 = int'(a1) + int'(b1) + int'(cin1);
      chk($sformatf("ex1_tbl_%0d", i), 64'({sum1, cout1}), 64'(tbl1[i]));
      chk($sformatf("ex1_mdl_%0d", i), 64'({cout1, sum1}), 64'(s1[1:0]));
    end

    // Registered path, WIDTH=1.
    @(negedge clk);
    a1 = 1; b1 = 1; cin1 = 1; iv1 = 1;
    @(posedge clk); #1;
    chk("reg1_sq", 64'(sq1), 64'd1);
    chk("reg1_cq", 64'(cq1), 64'd1);
    chk("reg1_ov", 64'(ov1), 64'd1);
    @(negedge clk);
    a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
    @(posedge clk); #1;
    chk("hold1_ov", 64'(ov1), 64'd0);
    chk("hold1_sq", 64'(sq1), 64'd1);
    chk("hold1_cq", 64'(cq1), 64'd1);

    // Carry rippling through all 8 bits.
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1; #1;
    chk("rip_sum", 64'(sum8), 64'h00);
    chk("rip_cout", 64'(cout8), 64'd1);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1; #1;
    chk("ones_sum", 64'(sum8), 64'hFF);
    chk("ones_cout", 64'(cout8), 64'd1);
    a8 = 8'h00; b8 = 8'h00; cin8 = 0; #1;
    chk("zero_sum", 64'(sum8), 64'h00);
    chk("zero_cout", 64'(cout8), 64'd0);

    // Back-to-back results with in_valid held high for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = bb_a[i]; b8 = bb_b[i]; cin8 = bb_c[i]; iv8 = 1;
      @(posedge clk); #1;
      r = ref_add8(bb_a[i], bb_b[i], bb_c[i]);
      chk($sformatf("b2b_sq_%0d", i), 64'(sq8), 64'(bb_s[i]));
      chk($sformatf("b2b_cq_%0d", i), 64'(cq8), 64'(bb_co[i]));
      chk($sformatf("b2b_mdl_%0d", i), 64'({cq8, sq8}), 64'(r));
      chk($sformatf("b2b_ov_%0d", i), 64'(ov8), 64'd1);
    end

    // Asynchronous reset asserted in the middle of a cycle.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h5A; cin8 = 1; iv8 = 1;
    @(posedge clk); #1;
    chk("load_sq", 64'(sq8), 64'h5A);
    chk("load_cq", 64'(cq8), 64'd1);
    @(negedge clk);
    iv8 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sq", 64'(sq8), 64'd0);
    chk("arst_cq", 64'(cq8), 64'd0);
    chk("arst_ov", 64'(ov8), 64'd0);
    a8 = 8'h12; b8 = 8'h34; cin8 = 0; iv8 = 1;
    @(posedge clk); #1;
    chk("rstcap_sq", 64'(sq8), 64'd0);
    chk("rstcap_ov", 64'(ov8), 64'd0);
    @(negedge clk);
    iv8 = 0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_sq", 64'(sq8), 64'd0);
    chk("post_ov", 64'(ov8), 64'd0);

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow output.
    bb_a = '{8'h7F, 8'h80, 8'hFF};
    bb_b = '{8'h01, 8'h80, 8'h01};
    bb_co = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = bb_a[i]; b8 = bb_b[i]; cin8 = 0; iv8 = 1;
      @(posedge clk); #1;
      chk($sformatf("ovf_%0d", i), 64'(of8), 64'(i < 2));
      chk($sformatf("ovf_mdl_%0d", i), 64'(of8), 64'(ref_ovf8(bb_a[i], bb_b[i], 1'b0)));
      chk($sformatf("ovf_cq_%0d", i), 64'(cq8), 64'(bb_co[i]));
    end
`endif

    // Random stimulus checked against the model. The model's registered
    // outputs follow the rule: load when valid, otherwise hold.
    @(negedge clk);
    iv8 = 0;
    @(posedge clk); #1;
    m_sq = sq8_model_init();
    m_cq = cq8;
    m_of = 1'b0;
`ifdef FULL_ADDER_OVF_EN
    m_of = of8;
`endif
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1'($urandom);
      #1;
      r = ref_add8(a8, b8, cin8);
      chk("rnd_comb", 64'({cout8, sum8}), 64'(r));
      m_ov = iv8;
      if (iv8) begin
        m_sq = r[7:0];
        m_cq = r[8];
        m_of = ref_ovf8(a8, b8, cin8);
      end
      @(posedge clk); #1;
      chk("rnd_sq", 64'(sq8), 64'(m_sq));
      chk("rnd_cq", 64'(cq8), 64'(m_cq));
      chk("rnd_ov", 64'(ov8), 64'(m_ov));
`ifdef FULL_ADDER_OVF_EN
      chk("rnd_ovf", 64'(of8), 64'(m_of));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // The random phase starts from the value the bench itself loaded most
  // recently: the registered value from the last directed capture.
  function automatic logic [7:0] sq8_model_init();
`ifdef FULL_ADDER_OVF_EN
    return 8'h00;  // last capture was 8'hFF + 8'h01 = 9'h100
`else
    return 8'h00;  // registers were cleared by the reset and nothing has been captured since
`endif
  endfunction

endmodule

// File: doc/full_adder_unit.md
Name: full_adder_unit

Overview:
- Parameterised ripple-carry adder. Each bit is a full-adder cell built from two half adders and an OR on the carries.
- Provides a combinational result path (sum, cout) and a registered, valid-qualified copy (sum_q, cout_q, out_valid).
- Used as the basic add primitive in datapaths. WIDTH=1 gives the classic 1-bit full adder (a, b, cin -> sum, cout).

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry in to bit 0
- in_valid  input  1  qualifies a/b/cin for capture into the output register
- sum  output  WIDTH  combinational sum, low WIDTH bits of a+b+cin
- cout  output  1  combinational carry out of bit WIDTH-1
- sum_q  output  WIDTH  registered sum
- cout_q  output  1  registered carry out
- out_valid  output  1  sum_q/cout_q hold a result captured on the previous edge with in_valid=1

Behaviour:
- Cell i (half adder = XOR/AND pair):
  - HA1: p_i = a_i^b_i, g_i = a_i&b_i
  - HA2: sum_i = p_i^c_i, t_i = p_i&c_i
  - c_{i+1} = g_i|t_i, with c_0 = cin and cout = c_WIDTH
- Arithmetic rule: {cout, sum} == a + b + cin, computed at WIDTH+1 bits. No saturation; the carry is the overflow indicator.
- The combinational path has zero latency: sum and cout follow the inputs with no dependence on clk or rst_n.
- Registered path, on posedge clk:
  - if in_valid=1: sum_q <= sum, cout_q <= cout
  - if in_valid=0: sum_q and cout_q hold their value
  - out_valid <= in_valid every cycle
- Latency is 1 cycle from in_valid sampled high to out_valid high with the matching result.
- Back-to-back in_valid gives one result per cycle. There is no backpressure.
- Reset: while rst_n=0, sum_q=0, cout_q=0 and out_valid=0 immediately, without waiting for a clock edge.
  - Deassertion is sampled on the next rising edge.
  - An in_valid pulse coinciding with reset is discarded.
- Boundary cases:
  - all-ones a and b with cin=1 gives sum = all-ones and cout = 1.
  - all-zero inputs give sum=0, cout=0.
  - cin alone propagates through the full ripple chain (a = all-ones, b = 0, cin = 1 gives sum = 0, cout = 1).
- X on any input may produce X on the combinational outputs. The registered outputs only capture when in_valid=1.

Optional Feature:
- Macro: FULL_ADDER_OVF_EN.
- When defined:
  - adds output port ovf_q (1 bit): registered signed overflow, computed as c_WIDTH ^ c_{WIDTH-1}.
  - captured under the same in_valid rule as sum_q and reset to 0 asynchronously.
  - for WIDTH=1, c_{WIDTH-1} is cin.
- When undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Exhaustive 1-bit (WIDTH=1), inputs a,b,cin stepped 000 through 111 -> {sum,cout} = 00, 10, 10, 01, 10, 01, 01, 11, checked combinationally at each step.
- Registered path (WIDTH=1): apply a=1, b=1, cin=1 with in_valid=1 for one cycle -> next edge gives sum_q=1, cout_q=1, out_valid=1. Then in_valid=0 -> out_valid=0 and sum_q/cout_q hold 1/1.
- Full carry ripple (WIDTH=8): a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1. Also a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Async reset: after loading sum_q=8'h5A, cout_q=1, drop rst_n mid-cycle -> sum_q=0, cout_q=0, out_valid=0 before the next edge. Assert in_valid during reset -> no capture.
- Back-to-back (WIDTH=8): in_valid high for 3 cycles with (3+4+0), (200+100+1), (0+0+0) -> sum_q/cout_q = 7/0, 45/1, 0/0 on consecutive cycles, out_valid=1 throughout.
- FULL_ADDER_OVF_EN (WIDTH=8):
  - a=8'h7F, b=8'h01, cin=0 -> ovf_q=1, cout_q=0.
  - a=8'h80, b=8'h80, cin=0 -> ovf_q=1, cout_q=1.
  - a=8'hFF, b=8'h01, cin=0 -> ovf_q=0, cout_q=1.
